// File: rtl/cpu_multicycle.sv
// Multi-cycle load/store CPU: FETCH/DECODE/EXEC/MEM/WB over one shared word-addressed memory port.
// Latency (zero-wait memory): 3 cycles NOP/BEQ/JMP/HALT, 4 ALU/ADDI/MUL/ST, 5 LD; +1 per wait cycle.
// Backpressure: each memory request holds req/we/addr/wdata stable until the mem_ready edge; FSM stalls meanwhile.
//
// Optional feature: define CPU_MUL_EN to implement opcode C as a single-cycle multiply; otherwise C is a NOP.
//
// Ports:
//   clk, rst          sole clock; synchronous active-high reset
//   mem_req/mem_we    request strobe and write select (we meaningful only while req is high)
//   mem_addr          word address (AW bits), mem_wdata store data
//   mem_rdata         read data, sampled only on an edge with mem_req && mem_ready
//   mem_ready         completes the current request at this edge
//   halted            sticky, set when HALT executes
//   retire            one-cycle pulse per completed instruction (registered, follows the final state edge)
module cpu_multicycle #(
    parameter int WIDTH     = 32,
    parameter int MEM_DEPTH = 2048,
    parameter int NREGS     = 16,
    parameter int RESET_PC  = 0,
    localparam int AW       = $clog2(MEM_DEPTH),
    localparam int RDW      = (WIDTH > 32) ? WIDTH : 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [RDW-1:0]   mem_rdata,
    input  logic             mem_ready,
    output logic             halted,
    output logic             retire
);

    localparam int RIW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
`ifdef CPU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'hC;
`endif
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]    pc_q, pc_next;
    logic [31:0]      ir_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [WIDTH-1:0] alu_res, imm_sx;
    logic [WIDTH-1:0] regs [NREGS];
    logic             run_q;      // low for one cycle after reset so the first request follows deassertion
    logic             retire_d;

    logic [3:0]       opcode;
    logic [RIW-1:0]   rd_idx, rs1_idx, rs2_idx;

    // Register indices beyond NREGS-1 alias back onto the implemented file.
    function automatic logic [RIW-1:0] ridx(input logic [3:0] r);
        return RIW'({28'd0, r} % NREGS);
    endfunction

    assign opcode  = ir_q[31:28];
    assign rd_idx  = ridx(ir_q[27:24]);
    assign rs1_idx = ridx(ir_q[23:20]);
    assign rs2_idx = ridx(ir_q[19:16]);
    assign imm_sx  = WIDTH'(signed'(ir_q[15:0]));

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:                alu_res = a_q + b_q;
            OP_SUB:                alu_res = a_q - b_q;
            OP_AND:                alu_res = a_q & b_q;
            OP_OR:                 alu_res = a_q | b_q;
            OP_XOR:                alu_res = a_q ^ b_q;
            OP_ADDI, OP_LD, OP_ST: alu_res = a_q + imm_sx;
`ifdef CPU_MUL_EN
            OP_MUL:                alu_res = a_q * b_q;
`endif
            default:               alu_res = '0;
        endcase
    end

    // PC arithmetic is done at AW bits so it wraps at MEM_DEPTH naturally.
    always_comb begin
        pc_next = pc_q + AW'(1);
        if (opcode == OP_BEQ && a_q == b_q)
            pc_next = pc_q + AW'(1) + AW'(imm_sx);
        else if (opcode == OP_JMP)
            pc_next = AW'(ir_q[15:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        retire_d  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                    if (mem_ready) state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: state_d = S_WB;
`ifdef CPU_MUL_EN
                    OP_MUL: state_d = S_WB;
`endif
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_HALT: begin
                        state_d  = S_HALTED;
                        retire_d = 1'b1;
                    end
                    default: begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (opcode == OP_ST);
                mem_addr = AW'(res_q);
                if (opcode == OP_ST) mem_wdata = b_q;
                if (mem_ready) begin
                    if (opcode == OP_ST) begin
                        state_d  = S_FETCH;
                        retire_d = 1'b1;
                    end else begin
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= AW'(RESET_PC);
            ir_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            run_q  <= 1'b0;
            halted <= 1'b0;
            retire <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            run_q  <= 1'b1;
            retire <= retire_d;
            case (state_q)
                S_FETCH: if (run_q && mem_ready) ir_q <= mem_rdata[31:0];
                S_DECODE: begin
                    a_q <= (rs1_idx == '0) ? '0 : regs[rs1_idx];
                    b_q <= (rs2_idx == '0) ? '0 : regs[rs2_idx];
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    pc_q  <= pc_next;
                    if (opcode == OP_HALT) halted <= 1'b1;
                end
                S_MEM: if (mem_ready && opcode == OP_LD) res_q <= mem_rdata[WIDTH-1:0];
                S_WB: if (rd_idx != '0) regs[rd_idx] <= res_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
module tb_cpu_multicycle;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req, mem_we, mem_ready, halted, retire;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    cpu_multicycle #(.WIDTH(32), .MEM_DEPTH(DEPTH), .NREGS(16), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .retire(retire)
    );

    always #5 clk = ~clk;

    logic [31:0]   mem [DEPTH];
    int            wait_n = 0;
    int            wcnt = 0;
    bit            hold = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    int            retire_cnt = 0, req_after_halt = 0, wait_cycles = 0, unstable = 0;
    bit            pend = 1'b0;
    logic [AW-1:0] p_addr;
    logic          p_we;
    logic [31:0]   p_wdata;
    logic [AW-1:0] fetch_log [$];
    int            tests = 0, fails = 0;
    int            cyc;

    assign mem_ready = mem_req && (wcnt >= wait_n) && !(hold && mem_addr == hold_addr);
    assign mem_rdata = mem[mem_addr];

    // Memory responder and bus monitors.
    always @(posedge clk) begin
        if (rst) begin
            retire_cnt <= 0; req_after_halt <= 0; wait_cycles <= 0; unstable <= 0;
            pend <= 1'b0; wcnt <= 0;
        end else begin
            if (retire) retire_cnt <= retire_cnt + 1;
            if (halted && mem_req) req_after_halt <= req_after_halt + 1;
            if (mem_req && pend && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
                unstable <= unstable + 1;
            if (mem_req && !mem_ready) begin
                wcnt <= wcnt + 1; wait_cycles <= wait_cycles + 1;
                pend <= 1'b1; p_addr <= mem_addr; p_we <= mem_we; p_wdata <= mem_wdata;
            end else begin
                wcnt <= 0; pend <= 1'b0;
            end
            if (mem_req && mem_ready) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                else        fetch_log.push_back(mem_addr);
            end
        end
    end

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic begin_prog();
        @(negedge clk);
        rst = 1'b1; hold = 1'b0; wait_n = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        fetch_log.delete();
    endtask

    task automatic go(input int waits);
        wait_n = waits;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(output int n);
        n = 0;
        while (!halted && n < 3000) begin
            @(posedge clk); #1; n++;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;

        // Reset state and first request timing
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {21'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        rst = 1'b0; #1;
        chk("req_low_at_release", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        chk("first_req", {31'b0, mem_req}, 32'd1);
        chk("first_fetch_addr", {21'b0, mem_addr}, 32'd0);

        // Basic program, zero-wait memory
        for (int w = 0; w <= 3; w += 3) begin
            begin_prog();
            mem[0] = ins(4'h6, 4'd1, 4'd0, 4'd0, 16'd5);
            mem[1] = ins(4'h6, 4'd2, 4'd0, 4'd0, 16'd7);
            mem[2] = ins(4'h1, 4'd3, 4'd1, 4'd2, 16'd0);
            mem[3] = ins(4'h8, 4'd0, 4'd0, 4'd3, 16'd100);
            mem[4] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
            go(w);
            run(cyc);
            repeat (3) @(posedge clk); #1;
            chk($sformatf("basic_w%0d_mem100", w), mem[100], 32'd12);
            chk($sformatf("basic_w%0d_halted", w), {31'b0, halted}, 32'd1);
            chk($sformatf("basic_w%0d_cycles", w), cyc, (w == 0) ? 32'd20 : 32'd38);
            chk($sformatf("basic_w%0d_retires", w), retire_cnt, 32'd5);
            chk($sformatf("basic_w%0d_req_after_halt", w), req_after_halt, 32'd0);
            chk($sformatf("basic_w%0d_wait_cycles", w), wait_cycles, (w == 0) ? 32'd0 : 32'd18);
            chk($sformatf("basic_w%0d_bus_stable", w), unstable, 32'd0);
        end

        // Branch loop: decrement r1 from 3 to 0, then store it
        begin_prog();
        mem[0] = ins(4'h6, 4'd1, 4'd0, 4'd0, 16'd3);
        mem[1] = ins(4'h6, 4'd1, 4'd1, 4'd0, 16'hFFFF);
        mem[2] = ins(4'h9, 4'd0, 4'd1, 4'd0, 16'd1);
        mem[3] = ins(4'hA, 4'd0, 4'd0, 4'd0, 16'd1);
        mem[4] = ins(4'h8, 4'd0, 4'd0, 4'd1, 16'd200);
        mem[5] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
        mem[200] = 32'hDEAD_BEEF;
        go(0);
        run(cyc);
        repeat (3) @(posedge clk); #1;
        chk("loop_r1", mem[200], 32'd0);
        chk("loop_halted", {31'b0, halted}, 32'd1);
        chk("loop_retires", retire_cnt, 32'd11);
        chk("loop_cycles", cyc, 32'd39);

        // Edge arithmetic, logic ops and loads
        begin_prog();
        mem[0]  = ins(4'h6, 4'd0, 4'd0, 4'd0, 16'd9);
        mem[1]  = ins(4'h8, 4'd0, 4'd0, 4'd0, 16'd300);
        mem[2]  = ins(4'h6, 4'd1, 4'd0, 4'd0, 16'hFFFF);
        mem[3]  = ins(4'h8, 4'd0, 4'd0, 4'd1, 16'd301);
        mem[4]  = ins(4'h6, 4'd1, 4'd1, 4'd0, 16'd1);
        mem[5]  = ins(4'h8, 4'd0, 4'd0, 4'd1, 16'd302);
        mem[6]  = ins(4'h6, 4'd2, 4'd0, 4'd0, 16'h0F0F);
        mem[7]  = ins(4'h6, 4'd3, 4'd0, 4'd0, 16'hFF00);
        mem[8]  = ins(4'h3, 4'd4, 4'd2, 4'd3, 16'd0);
        mem[9]  = ins(4'h4, 4'd5, 4'd2, 4'd3, 16'd0);
        mem[10] = ins(4'h5, 4'd6, 4'd2, 4'd3, 16'd0);
        mem[11] = ins(4'h2, 4'd7, 4'd2, 4'd3, 16'd0);
        mem[12] = ins(4'h8, 4'd0, 4'd0, 4'd4, 16'd303);
        mem[13] = ins(4'h8, 4'd0, 4'd0, 4'd5, 16'd304);
        mem[14] = ins(4'h8, 4'd0, 4'd0, 4'd6, 16'd305);
        mem[15] = ins(4'h8, 4'd0, 4'd0, 4'd7, 16'd306);
        mem[16] = ins(4'h7, 4'd8, 4'd0, 4'd0, 16'd301);
        mem[17] = ins(4'h8, 4'd0, 4'd0, 4'd8, 16'd307);
        mem[18] = ins(4'h6, 4'd9, 4'd0, 4'd0, 16'd400);
        mem[19] = ins(4'h7, 4'd10, 4'd9, 4'd0, 16'hFFF6);
        mem[20] = ins(4'h8, 4'd0, 4'd0, 4'd10, 16'd308);
        mem[21] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
        for (int i = 300; i <= 308; i++) mem[i] = 32'hA5A5_A5A5;
        mem[390] = 32'h1234_5678;
        go(0);
        run(cyc);
        chk("r0_write_discarded", mem[300], 32'h0000_0000);
        chk("addi_minus1", mem[301], 32'hFFFF_FFFF);
        chk("addi_wrap_to_0", mem[302], 32'h0000_0000);
        chk("and", mem[303], 32'h0000_0F00);
        chk("or", mem[304], 32'hFFFF_FF0F);
        chk("xor", mem[305], 32'hFFFF_F00F);
        chk("sub", mem[306], 32'h0000_100F);
        chk("ld_then_st", mem[307], 32'hFFFF_FFFF);
        chk("ld_neg_offset", mem[308], 32'h1234_5678);

        // PC wrap: NOP at MEM_DEPTH-1 is followed by a fetch from 0
        begin_prog();
        mem[0]    = ins(4'h9, 4'd0, 4'd1, 4'd0, 16'd1);
        mem[1]    = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
        mem[2]    = ins(4'h6, 4'd1, 4'd0, 4'd0, 16'd1);
        mem[3]    = ins(4'hA, 4'd0, 4'd0, 4'd0, 16'd2047);
        mem[2047] = ins(4'h0, 4'd0, 4'd0, 4'd0, 16'd0);
        go(0);
        run(cyc);
        repeat (2) @(posedge clk); #1;
        chk("wrap_fetch_count", fetch_log.size(), 32'd6);
        if (fetch_log.size() == 6) begin
            chk("wrap_fetch_2047", {21'b0, fetch_log[3]}, 32'd2047);
            chk("wrap_fetch_0", {21'b0, fetch_log[4]}, 32'd0);
            chk("wrap_fetch_halt", {21'b0, fetch_log[5]}, 32'd1);
        end
        chk("wrap_cycles", cyc, 32'd20);
        chk("wrap_retires", retire_cnt, 32'd6);

        // Reset while a load request is held in MEM
        begin_prog();
        mem[0] = ins(4'h6, 4'd1, 4'd0, 4'd0, 16'h11);
        mem[1] = ins(4'h7, 4'd1, 4'd0, 4'd0, 16'd500);
        mem[2] = ins(4'h8, 4'd0, 4'd0, 4'd1, 16'd501);
        mem[3] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
        mem[500] = 32'h0000_0077;
        hold = 1'b1; hold_addr = AW'(500);
        go(0);
        cyc = 0;
        while (!(mem_req && mem_addr == AW'(500)) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        repeat (2) @(posedge clk); #1;
        chk("ld_held_req", {31'b0, mem_req}, 32'd1);
        chk("ld_held_addr", {21'b0, mem_addr}, 32'd500);
        chk("ld_held_we", {31'b0, mem_we}, 32'd0);
        chk("ld_retires_before_rst", retire_cnt, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_req_low", {31'b0, mem_req}, 32'd0);
        @(negedge clk); rst = 1'b0; hold = 1'b0;
        @(posedge clk); #1;
        chk("abort_refetch_req", {31'b0, mem_req}, 32'd1);
        chk("abort_refetch_addr", {21'b0, mem_addr}, 32'd0);
        run(cyc);
        chk("abort_rerun_store", mem[501], 32'h0000_0077);

        // MUL
        begin_prog();
        mem[0] = ins(4'h6, 4'd1, 4'd0, 4'd0, 16'd6);
        mem[1] = ins(4'h6, 4'd2, 4'd0, 4'd0, 16'd7);
        mem[2] = ins(4'h6, 4'd3, 4'd0, 4'd0, 16'd5);
        mem[3] = ins(4'hC, 4'd3, 4'd1, 4'd2, 16'd0);
        mem[4] = ins(4'h8, 4'd0, 4'd0, 4'd3, 16'd600);
        mem[5] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
        go(0);
        run(cyc);
`ifdef CPU_MUL_EN
        chk("mul_result", mem[600], 32'd42);
        chk("mul_cycles", cyc, 32'd24);
`else
        chk("mul_as_nop_result", mem[600], 32'd5);
        chk("mul_as_nop_cycles", cyc, 32'd23);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
